// File: rtl/forward_hazard_unit_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
//   - Forward select encodings driven to the EX-stage 3:1 operand muxes
//   - stageRec_t: one shadow pipeline stage record of register tags
//   - BUBBLE: the all-zero, invalid stage record
//   - fwdSelect: select logic shared by operand A and operand B
package forward_hazard_unit_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dest;
    logic             regWrite;
    logic             memRead;
  } stageRec_t;

  localparam stageRec_t BUBBLE = '0;

  // EX/MEM is checked first because it holds the younger producer.
  // A load sitting in EX/MEM has no data yet, so a match there selects
  // the register file rather than falling through to MEM/WB.
  function automatic logic [1:0] fwdSelect(
    input logic             consumerValid,
    input logic [REG_W-1:0] src,
    input stageRec_t        exMem,
    input stageRec_t        memWb
  );
    logic [1:0] sel;
    sel = FWD_REGFILE;
    if (consumerValid) begin
      if (exMem.valid && exMem.regWrite && (exMem.dest != '0) && (exMem.dest == src)) begin
        sel = exMem.memRead ? FWD_REGFILE : FWD_EXMEM;
      end else if (memWb.valid && memWb.regWrite && (memWb.dest != '0) && (memWb.dest == src)) begin
        sel = FWD_MEMWB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/forward_hazard_unit_if.sv
// Decode-stage fields into the hazard unit and forward/stall results out.
//   master: the core (drives Id* and Flush, reads selects and Stall)
//   slave : the hazard unit
//   CNT_W : width of the saturating stall counter
interface forward_hazard_unit_if #(parameter int CNT_W = 16);
  import forward_hazard_unit_pkg::*;

  logic             IdValid;
  logic [REG_W-1:0] IdRs;
  logic [REG_W-1:0] IdRt;
  logic [REG_W-1:0] IdDest;
  logic             IdRegWrite;
  logic             IdMemRead;
  logic             Flush;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic             Stall;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output IdValid, IdRs, IdRt, IdDest, IdRegWrite, IdMemRead, Flush,
    input  ForwardA, ForwardB, Stall, StallCount
  );

  modport slave (
    input  IdValid, IdRs, IdRt, IdDest, IdRegWrite, IdMemRead, Flush,
    output ForwardA, ForwardB, Stall, StallCount
  );

endinterface

// File: rtl/forward_hazard_unit_fwd_stage_reg.sv
// One shadow pipeline stage register of register tags.
//   Clk   : core clock
//   Reset : synchronous, active-high; loads BUBBLE
//   dIn   : record entering the stage
//   qOut  : record held by the stage
module fwd_stage_reg
  import forward_hazard_unit_pkg::*;
(
  input  logic      Clk,
  input  logic      Reset,
  input  stageRec_t dIn,
  output stageRec_t qOut
);

  always_ff @(posedge Clk) begin
    if (Reset) qOut <= BUBBLE;
    else       qOut <= dIn;
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding select generation and load-use hazard detection.
// Tracks ID/EX, EX/MEM and MEM/WB register tags in its own shadow
// pipeline so the core only has to present decode-stage fields.
//   Clk    : core clock
//   Reset  : synchronous, active-high
//   hazIf  : slave side of forward_hazard_unit_if
//            in : IdValid, IdRs, IdRt, IdDest, IdRegWrite, IdMemRead, Flush
//            out: ForwardA, ForwardB, Stall, StallCount
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  forward_hazard_unit_if.slave  hazIf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stageRec_t idRecNext;
  stageRec_t idEx;
  stageRec_t exMem;
  stageRec_t memWb;
  logic      stall;
  logic [CNT_W-1:0] stallCnt;

  // Flush overrides the load-use check, so a killed consumer never stalls.
  always_comb begin
    stall = hazIf.IdValid && !hazIf.Flush
         && idEx.valid && idEx.memRead && (idEx.dest != '0)
         && ((idEx.dest == hazIf.IdRs) || (idEx.dest == hazIf.IdRt));
  end

  // On a stall the ID instruction stays in IF/ID and a bubble enters EX.
  always_comb begin
    idRecNext = BUBBLE;
    if (hazIf.IdValid && !stall && !hazIf.Flush) begin
      idRecNext.valid    = 1'b1;
      idRecNext.rs       = hazIf.IdRs;
      idRecNext.rt       = hazIf.IdRt;
      idRecNext.dest     = hazIf.IdDest;
      idRecNext.regWrite = hazIf.IdRegWrite;
      idRecNext.memRead  = hazIf.IdMemRead;
    end
  end

  fwd_stage_reg uIdEx  (.Clk(Clk), .Reset(Reset), .dIn(idRecNext), .qOut(idEx));
  fwd_stage_reg uExMem (.Clk(Clk), .Reset(Reset), .dIn(idEx),      .qOut(exMem));
  fwd_stage_reg uMemWb (.Clk(Clk), .Reset(Reset), .dIn(exMem),     .qOut(memWb));

  always_ff @(posedge Clk) begin
    if (Reset)                            stallCnt <= '0;
    else if (stall && stallCnt != CNT_MAX) stallCnt <= stallCnt + 1'b1;
  end

  assign hazIf.ForwardA   = fwdSelect(idEx.valid, idEx.rs, exMem, memWb);
  assign hazIf.ForwardB   = fwdSelect(idEx.valid, idEx.rt, exMem, memWb);
  assign hazIf.Stall      = stall;
  assign hazIf.StallCount = stallCnt;

endmodule

// File: tb/tb_forward_hazard_unit.sv
module tb_forward_hazard_unit;
  import forward_hazard_unit_pkg::*;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  forward_hazard_unit_if #(.CNT_W(16)) hIf ();
  forward_hazard_unit_if #(.CNT_W(2))  sIf ();

  forward_hazard_unit #(.CNT_W(16)) dut      (.Clk(Clk), .Reset(Reset), .hazIf(hIf.slave));
  forward_hazard_unit #(.CNT_W(2))  dutSmall (.Clk(Clk), .Reset(Reset), .hazIf(sIf.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dest, input logic rw, input logic mr, input logic fl);
    hIf.IdValid = v;  hIf.IdRs = rs; hIf.IdRt = rt; hIf.IdDest = dest;
    hIf.IdRegWrite = rw; hIf.IdMemRead = mr; hIf.Flush = fl;
    sIf.IdValid = v;  sIf.IdRs = rs; sIf.IdRt = rt; sIf.IdDest = dest;
    sIf.IdRegWrite = rw; sIf.IdMemRead = mr; sIf.Flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic nops(input int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    #1;
    checks++;
    if (hIf.ForwardA !== 2'b00 || hIf.ForwardB !== 2'b00 || hIf.Stall !== 1'b0 || hIf.StallCount !== 16'd0) begin
      errors++;
      $display("FAIL reset: fa=%b fb=%b stall=%b cnt=%0d, need 00 00 0 0",
               hIf.ForwardA, hIf.ForwardB, hIf.Stall, hIf.StallCount);
    end
  endtask

  task automatic test_exmem_fwd();
    drive(1, 1, 2, 3, 1, 0, 0); tick();        // add $3,$1,$2
    drive(1, 3, 5, 4, 1, 0, 0);                // sub $4,$3,$5 in ID
    checks++;
    if (hIf.Stall !== 1'b0) begin errors++; $display("FAIL exmem_stall: got %b need 0", hIf.Stall); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (hIf.ForwardA !== 2'b10 || hIf.ForwardB !== 2'b00) begin
      errors++; $display("FAIL exmem_fwd: fa=%b fb=%b need 10 00", hIf.ForwardA, hIf.ForwardB);
    end
    nops(3);
  endtask

  task automatic test_memwb_fwd();
    drive(1, 1, 2, 3, 1, 0, 0); tick();        // add $3
    drive(0, 0, 0, 0, 0, 0, 0); tick();        // nop
    drive(1, 7, 3, 6, 1, 0, 0); tick();        // or $6,$7,$3
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (hIf.ForwardA !== 2'b00 || hIf.ForwardB !== 2'b01) begin
      errors++; $display("FAIL memwb_fwd: fa=%b fb=%b need 00 01", hIf.ForwardA, hIf.ForwardB);
    end
    nops(3);
    drive(1, 1, 2, 3, 1, 0, 0); tick();
    nops(2);
    drive(1, 7, 3, 6, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (hIf.ForwardA !== 2'b00 || hIf.ForwardB !== 2'b00) begin
      errors++; $display("FAIL regfile_fwd: fa=%b fb=%b need 00 00", hIf.ForwardA, hIf.ForwardB);
    end
    nops(3);
  endtask

  task automatic test_load_use();
    drive(1, 9, 8, 8, 1, 1, 0); tick();        // lw $8,0($9)
    drive(1, 8, 8, 10, 1, 0, 0);               // add $10,$8,$8
    checks++;
    if (hIf.Stall !== 1'b1 || hIf.StallCount !== 16'd0) begin
      errors++; $display("FAIL load_use_stall: stall=%b cnt=%0d need 1 0", hIf.Stall, hIf.StallCount);
    end
    tick();
    checks++;
    if (hIf.Stall !== 1'b0 || hIf.StallCount !== 16'd1) begin
      errors++; $display("FAIL load_use_release: stall=%b cnt=%0d need 0 1", hIf.Stall, hIf.StallCount);
    end
    checks++;
    if (hIf.ForwardA !== 2'b00 || hIf.ForwardB !== 2'b00) begin
      errors++; $display("FAIL bubble_fwd: fa=%b fb=%b need 00 00", hIf.ForwardA, hIf.ForwardB);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (hIf.ForwardA !== 2'b01 || hIf.ForwardB !== 2'b01) begin
      errors++; $display("FAIL load_use_fwd: fa=%b fb=%b need 01 01", hIf.ForwardA, hIf.ForwardB);
    end
    nops(3);
  endtask

  task automatic test_priority_r0();
    drive(1, 1, 2, 3, 1, 0, 0); tick();
    drive(1, 4, 5, 3, 1, 0, 0); tick();
    drive(1, 3, 3, 4, 1, 0, 0); tick();        // sub $4,$3,$3
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (hIf.ForwardA !== 2'b10 || hIf.ForwardB !== 2'b10) begin
      errors++; $display("FAIL priority: fa=%b fb=%b need 10 10", hIf.ForwardA, hIf.ForwardB);
    end
    nops(3);
    drive(1, 1, 2, 0, 1, 0, 0); tick();        // add $0
    drive(1, 0, 0, 4, 1, 0, 0); tick();        // sub $4,$0,$0
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (hIf.ForwardA !== 2'b00 || hIf.ForwardB !== 2'b00) begin
      errors++; $display("FAIL r0_exmem: fa=%b fb=%b need 00 00", hIf.ForwardA, hIf.ForwardB);
    end
    nops(3);
    drive(1, 1, 2, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 4, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (hIf.ForwardA !== 2'b00 || hIf.ForwardB !== 2'b00) begin
      errors++; $display("FAIL r0_memwb: fa=%b fb=%b need 00 00", hIf.ForwardA, hIf.ForwardB);
    end
    nops(3);
  endtask

  task automatic test_flush_reset();
    logic [15:0] cntBefore;
    cntBefore = hIf.StallCount;
    drive(1, 9, 8, 8, 1, 1, 0); tick();        // lw $8
    drive(1, 8, 2, 10, 1, 0, 1);               // add $10,$8,$2 killed by Flush
    checks++;
    if (hIf.Stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b need 0", hIf.Stall); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (hIf.StallCount !== cntBefore || hIf.ForwardA !== 2'b00 || hIf.ForwardB !== 2'b00) begin
      errors++; $display("FAIL flush_bubble: cnt=%0d fa=%b fb=%b need %0d 00 00",
                         hIf.StallCount, hIf.ForwardA, hIf.ForwardB, cntBefore);
    end
    tick();
    checks++;
    if (hIf.ForwardA !== 2'b00 || hIf.ForwardB !== 2'b00) begin
      errors++; $display("FAIL flush_no_issue: fa=%b fb=%b need 00 00", hIf.ForwardA, hIf.ForwardB);
    end
    nops(3);
    drive(1, 9, 8, 8, 1, 1, 0); tick();
    drive(1, 8, 8, 10, 1, 0, 0);
    checks++;
    if (hIf.Stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %b need 1", hIf.Stall); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (hIf.Stall !== 1'b0 || hIf.ForwardA !== 2'b00 || hIf.ForwardB !== 2'b00 || hIf.StallCount !== 16'd0) begin
      errors++; $display("FAIL reset_mid_stall: stall=%b fa=%b fb=%b cnt=%0d need 0 00 00 0",
                         hIf.Stall, hIf.ForwardA, hIf.ForwardB, hIf.StallCount);
    end
    nops(3);
  endtask

  task automatic test_saturation();
    logic [1:0] expSmall;
    Reset = 1'b1; tick(); Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 9, 8, 8, 1, 1, 0); tick();
      drive(1, 8, 8, 10, 1, 0, 0); tick();
      expSmall = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++;
      if (sIf.StallCount !== expSmall) begin
        errors++; $display("FAIL sat_count[%0d]: got %0d need %0d", i, sIf.StallCount, expSmall);
      end
      nops(4);
    end
    checks++;
    if (hIf.StallCount !== 16'd5) begin
      errors++; $display("FAIL wide_count: got %0d need 5", hIf.StallCount);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_exmem_fwd();
    test_memwb_fwd();
    test_load_use();
    test_priority_r0();
    test_flush_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
